// File: rtl/cpu_id_if.sv
// cpu_id_if: fetch, write-back and ID/EX signals of the decode stage
interface cpu_id_if;
    logic [31:0] if_pc;
    logic [31:0] if_ins;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_ins;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_dest;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [31:0] stall_count;

    modport master (
        output if_pc, if_ins, flush, wb_we, wb_addr, wb_data,
        input  stall, ex_valid, ex_pc, ex_ins, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_dest, ex_reg_write, ex_mem_read, stall_count
    );

    modport slave (
        input  if_pc, if_ins, flush, wb_we, wb_addr, wb_data,
        output stall, ex_valid, ex_pc, ex_ins, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_dest, ex_reg_write, ex_mem_read, stall_count
    );
endinterface

// File: rtl/cpu_id.sv
// cpu_id: MIPS decode stage with register file, load-use stall and ID/EX register
module cpu_id #(
    parameter int REG_COUNT = 32
) (
    input logic   clk,
    input logic   clr,
    cpu_id_if.slave bus
);
    logic [31:0] regs [REG_COUNT];
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  dest;
    logic        writes;
    logic        mem_read;
    logic        hazard;
    logic        bubble;
    logic        wb_hit;
    logic [31:0] imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    // decode, bypassed register reads and load-use detection against ID/EX
    always_comb begin
        opcode   = bus.if_ins[31:26];
        rs       = bus.if_ins[25:21];
        rt       = bus.if_ins[20:16];
        rd       = bus.if_ins[15:11];
        funct    = bus.if_ins[5:0];
        writes   = opcode == 6'h00 ? funct != 6'h08
                 : (opcode == 6'h23 || opcode[5:3] == 3'b001 || opcode == 6'h03);
        dest     = opcode == 6'h00 ? rd : opcode == 6'h03 ? 5'd31 : rt;
        mem_read = opcode == 6'h23;
        imm      = opcode[5:2] == 4'b0011 ? {16'h0, bus.if_ins[15:0]}
                                          : {{16{bus.if_ins[15]}}, bus.if_ins[15:0]};
        wb_hit   = bus.wb_we && bus.wb_addr != 5'd0;
        rs_data  = (wb_hit && bus.wb_addr == rs) ? bus.wb_data : regs[rs];
        rt_data  = (wb_hit && bus.wb_addr == rt) ? bus.wb_data : regs[rt];
        hazard   = bus.ex_valid && bus.ex_mem_read && bus.ex_dest != 5'd0
                && (bus.ex_dest == rs || bus.ex_dest == rt);
        bubble   = bus.flush || hazard;
        bus.stall = hazard && !bus.flush;
    end

    // register file; entry 0 is never written so it stays zero from reset
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (wb_hit) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // ID/EX pipeline register, loading all-zero bubbles on flush or hazard
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_pc        <= '0;
            bus.ex_ins       <= '0;
            bus.ex_rs_data   <= '0;
            bus.ex_rt_data   <= '0;
            bus.ex_imm       <= '0;
            bus.ex_rs        <= '0;
            bus.ex_rt        <= '0;
            bus.ex_dest      <= '0;
            bus.ex_reg_write <= 1'b0;
            bus.ex_mem_read  <= 1'b0;
        end else begin
            bus.ex_valid     <= !bubble;
            bus.ex_pc        <= bubble ? '0 : bus.if_pc;
            bus.ex_ins       <= bubble ? '0 : bus.if_ins;
            bus.ex_rs_data   <= bubble ? '0 : rs_data;
            bus.ex_rt_data   <= bubble ? '0 : rt_data;
            bus.ex_imm       <= bubble ? '0 : imm;
            bus.ex_rs        <= bubble ? '0 : rs;
            bus.ex_rt        <= bubble ? '0 : rt;
            bus.ex_dest      <= bubble ? '0 : dest;
            bus.ex_reg_write <= !bubble && writes && dest != 5'd0;
            bus.ex_mem_read  <= !bubble && mem_read;
        end
    end

    // count cycles in which fetch was told to hold
    always_ff @(posedge clk or posedge clr) begin
        if (clr) bus.stall_count <= '0;
        else if (bus.stall) bus.stall_count <= bus.stall_count + 32'd1;
    end
endmodule

// File: tb/tb_cpu_id.sv
// tb_cpu_id: directed and randomized checks of the decode stage against a reference model
module tb_cpu_id;
    logic clk;
    logic clr;
    int   checks;
    int   errors;

    cpu_id_if bus();

    cpu_id #(.REG_COUNT(32)) dut (.clk(clk), .clr(clr), .bus(bus));

    localparam logic [31:0] LW_R2   = 32'h8C22_0000;
    localparam logic [31:0] ADD_R3  = 32'h0044_1820;
    localparam logic [31:0] ADD_R15 = 32'h00A0_0820;
    localparam logic [31:0] ADD_R00 = 32'h0000_0820;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic present(input logic [31:0] ins);
        bus.if_ins = ins;
        bus.if_pc  = bus.if_pc + 32'd1;
    endtask

    function automatic void ref_decode(input logic [31:0] ins, output logic [4:0] dest,
                                       output logic wr, output logic mr, output logic [31:0] imm);
        int op;
        op   = int'(ins[31:26]);
        dest = 5'd0;
        wr   = 1'b0;
        mr   = 1'b0;
        if (op == 0) begin
            dest = ins[15:11];
            wr   = int'(ins[5:0]) != 8;
        end else if (op == 35) begin
            dest = ins[20:16];
            wr   = 1'b1;
            mr   = 1'b1;
        end else if (op >= 8 && op <= 15) begin
            dest = ins[20:16];
            wr   = 1'b1;
        end else if (op == 3) begin
            dest = 5'd31;
            wr   = 1'b1;
        end
        if (op >= 12 && op <= 15) imm = 32'(ins[15:0]);
        else imm = 32'($signed(ins[15:0]));
    endfunction

    task automatic test_reset;
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.ex_valid); end
        checks++; if (bus.stall_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.stall_count); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
        clr = 1'b0;
        bus.wb_we = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h1234;
        present(32'h0);
        tick;
        bus.wb_we = 1'b0;
        present(LW_R2); tick;
        present(ADD_R3); tick;
        present(LW_R2); tick;
        present(ADD_R3); #1;
        checks++; if (bus.stall !== 1'b1 || bus.stall_count !== 32'd1) begin errors++; $display("FAIL pre_reset_stall: got stall %b count %0d expected 1 1", bus.stall, bus.stall_count); end
        clr = 1'b1; #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_mid_stall: got %b expected 0", bus.stall); end
        checks++; if ({bus.ex_valid, bus.ex_pc, bus.ex_ins, bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm, bus.ex_rs, bus.ex_rt, bus.ex_dest, bus.ex_reg_write, bus.ex_mem_read} !== '0) begin errors++; $display("FAIL reset_ex: got valid %b ins %h dest %0d expected all zero", bus.ex_valid, bus.ex_ins, bus.ex_dest); end
        checks++; if (bus.stall_count !== 32'd0) begin errors++; $display("FAIL reset_count_clear: got %0d expected 0", bus.stall_count); end
        clr = 1'b0;
        present(ADD_R15); tick;
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rs_data !== 32'd0 || bus.ex_dest !== 5'd1) begin errors++; $display("FAIL reset_regfile: got valid %b rs_data %h dest %0d expected 1 0 1", bus.ex_valid, bus.ex_rs_data, bus.ex_dest); end
    endtask

    task automatic test_load_use;
        present(32'h0); tick;
        present(LW_R2); tick;
        checks++; if (bus.ex_mem_read !== 1'b1 || bus.ex_dest !== 5'd2 || bus.ex_reg_write !== 1'b1) begin errors++; $display("FAIL lw_decode: got mr %b dest %0d rw %b expected 1 2 1", bus.ex_mem_read, bus.ex_dest, bus.ex_reg_write); end
        present(ADD_R3); #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b expected 1", bus.stall); end
        tick;
        checks++; if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_mem_read !== 1'b0) begin errors++; $display("FAIL load_use_bubble: got valid %b rw %b mr %b expected 0 0 0", bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL load_use_one_cycle: got %b expected 0", bus.stall); end
        tick;
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_ins !== ADD_R3 || bus.ex_dest !== 5'd3) begin errors++; $display("FAIL load_use_issue: got valid %b ins %h dest %0d expected 1 %h 3", bus.ex_valid, bus.ex_ins, bus.ex_dest, ADD_R3); end
        checks++; if (bus.stall_count !== 32'd1) begin errors++; $display("FAIL load_use_count: got %0d expected 1", bus.stall_count); end
    endtask

    task automatic test_flush_priority;
        present(LW_R2); tick;
        present(ADD_R3); bus.flush = 1'b1; #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", bus.stall); end
        tick;
        bus.flush = 1'b0;
        checks++; if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_mem_read !== 1'b0 || bus.ex_ins !== 32'd0) begin errors++; $display("FAIL flush_bubble: got valid %b rw %b mr %b ins %h expected 0 0 0 0", bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_ins); end
        checks++; if (bus.stall_count !== 32'd1) begin errors++; $display("FAIL flush_count: got %0d expected 1", bus.stall_count); end
    endtask

    task automatic test_bypass;
        bus.wb_we = 1'b1; bus.wb_addr = 5'd8; bus.wb_data = 32'hDEAD_BEEF;
        present(32'h2109_FFFF); tick;
        bus.wb_we = 1'b0;
        checks++; if (bus.ex_rs_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_data: got %h expected deadbeef", bus.ex_rs_data); end
        checks++; if (bus.ex_imm !== 32'hFFFF_FFFF || bus.ex_dest !== 5'd9 || bus.ex_reg_write !== 1'b1) begin errors++; $display("FAIL bypass_decode: got imm %h dest %0d rw %b expected ffffffff 9 1", bus.ex_imm, bus.ex_dest, bus.ex_reg_write); end
    endtask

    task automatic test_decode;
        present(32'h3407_8001); tick;
        checks++; if (bus.ex_imm !== 32'h0000_8001 || bus.ex_dest !== 5'd7 || bus.ex_reg_write !== 1'b1) begin errors++; $display("FAIL ori: got imm %h dest %0d rw %b expected 00008001 7 1", bus.ex_imm, bus.ex_dest, bus.ex_reg_write); end
        present(32'h0C00_0010); tick;
        checks++; if (bus.ex_dest !== 5'd31 || bus.ex_reg_write !== 1'b1) begin errors++; $display("FAIL jal: got dest %0d rw %b expected 31 1", bus.ex_dest, bus.ex_reg_write); end
        present(32'h03E0_0008); tick;
        checks++; if (bus.ex_reg_write !== 1'b0 || bus.ex_valid !== 1'b1) begin errors++; $display("FAIL jr: got rw %b valid %b expected 0 1", bus.ex_reg_write, bus.ex_valid); end
        present(32'h0000_0000); tick;
        checks++; if (bus.ex_reg_write !== 1'b0 || bus.ex_valid !== 1'b1) begin errors++; $display("FAIL sll_r0: got rw %b valid %b expected 0 1", bus.ex_reg_write, bus.ex_valid); end
    endtask

    task automatic test_reg0;
        bus.wb_we = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
        present(ADD_R00); tick;
        checks++; if (bus.ex_rs_data !== 32'd0 || bus.ex_rt_data !== 32'd0) begin errors++; $display("FAIL reg0_bypass: got %h %h expected 0 0", bus.ex_rs_data, bus.ex_rt_data); end
        bus.wb_we = 1'b0;
        present(ADD_R00); tick;
        checks++; if (bus.ex_rs_data !== 32'd0 || bus.ex_rt_data !== 32'd0) begin errors++; $display("FAIL reg0_read: got %h %h expected 0 0", bus.ex_rs_data, bus.ex_rt_data); end
    endtask

    task automatic test_random;
        logic [5:0]  ops [12];
        logic [31:0] mregs [32];
        logic [31:0] ins;
        logic [31:0] m_pc, m_ins, m_rsd, m_rtd, m_imm, m_sc, imm;
        logic [4:0]  m_rs, m_rt, m_dest, rs, rt, dest;
        logic        m_valid, m_mr, m_rw, m_dchk, wr, mr, hz, es;
        ops = '{6'h00, 6'h00, 6'h23, 6'h23, 6'h08, 6'h09, 6'h0C, 6'h0F, 6'h03, 6'h02, 6'h04, 6'h2B};
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        {m_pc, m_ins, m_rsd, m_rtd, m_imm, m_sc} = '0;
        {m_rs, m_rt, m_dest, m_valid, m_mr, m_rw} = '0;
        m_dchk = 1'b1;
        bus.flush = 1'b0; bus.wb_we = 1'b0;
        clr = 1'b1; #1; clr = 1'b0;
        for (int n = 0; n < 600; n++) begin
            ins = {($urandom_range(15) == 0) ? 6'($urandom) : ops[$urandom_range(11)],
                   5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
                   5'($urandom), ($urandom_range(3) == 0) ? 6'h08 : 6'($urandom)};
            bus.if_ins  = ins;
            bus.if_pc   = $urandom;
            bus.flush   = $urandom_range(7) == 0;
            bus.wb_we   = 1'($urandom);
            bus.wb_addr = 5'($urandom_range(7));
            bus.wb_data = $urandom;
            #1;
            rs = ins[25:21];
            rt = ins[20:16];
            hz = m_valid && m_mr && m_dest != 0 && (m_dest == rs || m_dest == rt);
            es = hz && !bus.flush;
            checks++; if (bus.stall !== es) begin errors++; $display("FAIL rnd_stall[%0d]: got %b expected %b", n, bus.stall, es); end
            ref_decode(ins, dest, wr, mr, imm);
            if (bus.flush || hz) begin
                {m_pc, m_ins, m_rsd, m_rtd, m_imm} = '0;
                {m_rs, m_rt, m_dest, m_valid, m_mr, m_rw} = '0;
                m_dchk = 1'b1;
            end else begin
                m_valid = 1'b1;
                m_pc    = bus.if_pc;
                m_ins   = ins;
                m_rsd   = rs == 0 ? 32'd0 : (bus.wb_we && bus.wb_addr == rs) ? bus.wb_data : mregs[rs];
                m_rtd   = rt == 0 ? 32'd0 : (bus.wb_we && bus.wb_addr == rt) ? bus.wb_data : mregs[rt];
                m_imm   = imm;
                m_rs    = rs;
                m_rt    = rt;
                m_dest  = dest;
                m_dchk  = wr;
                m_rw    = wr && dest != 0;
                m_mr    = mr;
            end
            if (bus.wb_we && bus.wb_addr != 0) mregs[bus.wb_addr] = bus.wb_data;
            m_sc = m_sc + 32'(es);
            tick;
            checks++; if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read} !== {m_valid, m_rw, m_mr}) begin errors++; $display("FAIL rnd_flags[%0d]: got %b%b%b expected %b%b%b", n, bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, m_valid, m_rw, m_mr); end
            checks++; if (bus.ex_pc !== m_pc || bus.ex_ins !== m_ins) begin errors++; $display("FAIL rnd_pc_ins[%0d]: got %h %h expected %h %h", n, bus.ex_pc, bus.ex_ins, m_pc, m_ins); end
            checks++; if (bus.ex_rs_data !== m_rsd || bus.ex_rt_data !== m_rtd) begin errors++; $display("FAIL rnd_data[%0d]: got %h %h expected %h %h", n, bus.ex_rs_data, bus.ex_rt_data, m_rsd, m_rtd); end
            checks++; if (bus.ex_imm !== m_imm || bus.ex_rs !== m_rs || bus.ex_rt !== m_rt) begin errors++; $display("FAIL rnd_fields[%0d]: got %h %0d %0d expected %h %0d %0d", n, bus.ex_imm, bus.ex_rs, bus.ex_rt, m_imm, m_rs, m_rt); end
            if (m_dchk) begin
                checks++; if (bus.ex_dest !== m_dest) begin errors++; $display("FAIL rnd_dest[%0d]: got %0d expected %0d", n, bus.ex_dest, m_dest); end
            end
            checks++; if (bus.stall_count !== m_sc) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", n, bus.stall_count, m_sc); end
        end
        bus.flush = 1'b0;
        bus.wb_we = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr = 1'b1;
        bus.if_pc = 32'd0; bus.if_ins = 32'd0; bus.flush = 1'b0;
        bus.wb_we = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0;
        tick; tick;
        test_reset;
        test_load_use;
        test_flush_priority;
        test_bypass;
        test_decode;
        test_reg0;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_id.md
# cpu_id

Instruction-decode stage of the pipelined MIPS core, directly downstream of the fetch stage. Consumes the fetch stage's registered `current_pc`/`ins` and owns the 32×32 register file. Detects load-use hazards against the instruction it is handing to EX, and returns a combinational `stall` to fetch. Registers decoded fields, operands and control flags into the ID/EX pipeline register, inserting bubbles on stall or flush.

## Interface
Parameters:
- `REG_COUNT`, 32: number of architectural registers; register 0 reads as zero.

Ports:
- `clk`  in  1  global clock; all state updates on the rising edge.
- `clr`  in  1  reset; asynchronous, active-high.
- `if_pc`  in  32  PC of the instruction in the IF/ID register (word-addressed).
- `if_ins`  in  32  instruction word in the IF/ID register.
- `flush`  in  1  from EX: taken branch or jump; squashes the instruction now in ID.
- `wb_we`  in  1  write-back enable.
- `wb_addr`  in  5  write-back register index.
- `wb_data`  in  32  write-back data.
- `stall`  out  1  combinational: `hazard & ~flush`; fetch holds PC and IF/ID while high.
- `ex_valid`  out  1  ID/EX holds a real instruction.
- `ex_pc`, `ex_ins`  out  32 each  registered copies of `if_pc` and `if_ins`.
- `ex_rs_data`, `ex_rt_data`  out  32 each  register-file read data, with write-through bypass applied.
- `ex_imm`  out  32  extended immediate.
- `ex_rs`, `ex_rt`, `ex_dest`  out  5 each  source fields and destination register.
- `ex_reg_write`  out  1  instruction writes `ex_dest`.
- `ex_mem_read`  out  1  instruction is a load (`lw`).
- `stall_count`  out  32  number of cycles in which `stall` was high since reset.

## Operation
- Field split: opcode = `ins[31:26]`, rs = `[25:21]`, rt = `[20:16]`, rd = `[15:11]`, funct = `[5:0]`, imm = `[15:0]`.
- Decode by opcode:
  - 0x00 (R-type): dest = rd; write = 1, except funct 0x08 (`jr`), which writes 0.
  - 0x23 (`lw`): dest = rt; write = 1; mem_read = 1.
  - 0x08–0x0F (ALU-immediate): dest = rt; write = 1.
  - 0x03 (`jal`): dest = 31; write = 1.
  - 0x02, 0x04, 0x05, 0x2B, and all other opcodes: write = 0; mem_read = 0.
- `ex_reg_write` is forced to 0 whenever dest = 0.
- Immediate extension: zero-extended for opcodes 0x0C, 0x0D, 0x0E, 0x0F; sign-extended for all others.
- Register file:
  - Two combinational read ports (rs, rt) and one write port.
  - Write occurs at the rising edge when `wb_we` is high and `wb_addr` ≠ 0.
  - Register 0 is never written and always reads 0.
  - Write-through bypass: if `wb_we` is high, `wb_addr` ≠ 0 and `wb_addr` equals the read index, the read returns `wb_data` in the same cycle.
- Load-use hazard: `hazard = ex_valid & ex_mem_read & (ex_dest != 0) & (ex_dest == rs | ex_dest == rt)`.
  - The comparison uses the raw rs/rt fields regardless of opcode (conservative).
- ID/EX register update at each rising edge:
  - `flush` = 1: bubble. `ex_valid`, `ex_reg_write` and `ex_mem_read` load 0; the other fields are don't-care but load 0.
  - Otherwise, `hazard` = 1: bubble, same as flush.
  - Otherwise: load the decoded instruction with `ex_valid` = 1.
- Flush takes priority over hazard. With both high, `stall` = 0, so fetch redirects and the squashed load-use pair never stalls.
- `stall_count` increments by 1 on each edge where `stall` = 1 and wraps modulo 2^32.

## Timing
- Decode and hazard latency is one cycle: the instruction in IF/ID during cycle N appears on `ex_*` after edge N.
- `stall` is purely combinational from the ID/EX state and `if_ins`, with no registered delay.
  - A single load-use stall lasts exactly one cycle, because the bubble clears `ex_mem_read`.
- Register-file write at edge N is visible to reads after edge N; the bypass also makes it visible during cycle N.
- Asynchronous `clr` assertion immediately forces:
  - all `ex_*` outputs to 0, including `ex_valid` = 0;
  - `stall_count` to 0;
  - all 32 registers to 0;
  - `stall` to 0, since `ex_valid` = 0.
- Reset mid-stall drops `stall` in the same cycle; the first edge after `clr` falls loads whatever instruction fetch presents.
- A write-back to register 0 is discarded, including the bypass path.

## Test plan
- Reset:
  - Write r5 = 0x1234.
  - Pulse `clr` between clock edges -> all `ex_*` = 0, `stall_count` = 0, and a subsequent `add r1,r5,r0` reads `ex_rs_data` = 0.
- Bypass:
  - Drive `wb_we` = 1, `wb_addr` = 8, `wb_data` = 0xDEADBEEF.
  - In the same cycle, present `addi r9,r8,-1` (0x2109FFFF) -> after the edge: `ex_rs_data` = 0xDEADBEEF, `ex_imm` = 0xFFFFFFFF, `ex_dest` = 9, `ex_reg_write` = 1.
- Load-use:
  - Issue `lw r2,0(r1)`, then `add r3,r2,r4`.
  - Expected: `stall` = 1 for exactly one cycle, followed by one bubble (`ex_valid` = 0), then `add` with `ex_valid` = 1; `stall_count` = 1.
- Flush priority:
  - Set up the same load-use pair with `flush` = 1 during the hazard cycle.
  - Expected: `stall` = 0, ID/EX = bubble, `stall_count` unchanged.
- Decode:
  - `ori r7,r0,0x8001` -> `ex_imm` = 0x00008001.
  - `jal` -> `ex_dest` = 31, `ex_reg_write` = 1.
  - `jr r31` -> `ex_reg_write` = 0.
  - `sll r0,r0,0` (0x00000000) -> `ex_reg_write` = 0.
- Register 0:
  - `wb_we` = 1, `wb_addr` = 0, `wb_data` = 0xFFFFFFFF, then read r0 -> 0.
